zx_vram_bridge: RTL

//  Owns the single port of the 8 KB ZX screen RAM (pixels 0x0000-0x17FF, attrs 0x1800-0x1AFF)
//  and arbitrates it between the Z80 bus and the ZX video generator, which sits downstream.

---
 rtl/zx_video_pkg.sv | 24 ++
 rtl/zx_sync_fifo.sv | 55 +++++
 rtl/zx_vram_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/zx_video_pkg.sv
// Shared ZX screen-RAM constants and types for the VRAM bridge and its FIFO.
package zx_video_pkg;

  localparam int          VRAM_AW      = 13;
  localparam logic [15:0] ZX_SCR_BASE  = 16'h4000;
  localparam int unsigned ZX_SCR_SIZE  = 6912;
  localparam logic [15:0] ZX_RESV_MASK = 16'h0006;

  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         data;
  } vram_wr_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PEND,
    RD_DATA
  } rd_st_e;

  function automatic logic phase_reserved(input logic [15:0] mask, input logic [3:0] phase);
    return mask[phase];
  endfunction

endpackage

// File: rtl/zx_sync_fifo.sv
// Single-clock FIFO with registered full/empty and extra-MSB wrap pointers.
module zx_sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= (wr_ptr_d == rd_ptr_d);
      // Same slot index but opposite lap bit means the writer is a full lap ahead.
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/zx_vram_bridge.sv
// Arbitrates the single-port ZX screen RAM between fixed video slots and buffered Z80 traffic.
// Writes drain from a FIFO in free slots; reads wait for an empty FIFO and a free slot.
module zx_vram_bridge
  import zx_video_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] RESV_MASK  = ZX_RESV_MASK,
  parameter logic [15:0] SCR_BASE   = ZX_SCR_BASE,
  parameter int unsigned SCR_SIZE   = ZX_SCR_SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         vid_phase,
  input  logic [VRAM_AW-1:0] video_addr,
  output logic [7:0]         video_data,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  input  logic               cpu_we,
  input  logic               cpu_rd,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_rvalid,
  output logic               cpu_wait,
  output logic [VRAM_AW-1:0] ram_addr,
  output logic [7:0]         ram_wdata,
  output logic               ram_we,
  input  logic [7:0]         ram_rdata
);

  localparam logic [16:0] SCR_LO = {1'b0, SCR_BASE};
  localparam logic [16:0] SCR_HI = SCR_LO + 17'(SCR_SIZE);

  rd_st_e             st_q;
  logic [VRAM_AW-1:0] rd_off_q;
  logic [7:0]         cpu_rdata_q;
  logic               cpu_rvalid_q;
  logic [7:0]         video_data_q;
  logic               resv_q;

  logic               hit, resv, free_slot;
  logic [VRAM_AW-1:0] cpu_off;
  logic               wr_hit, rd_hit, push, pop, rd_go;
  logic               fifo_full, fifo_empty;
  vram_wr_t           wr_ent, head;

  assign hit     = ({1'b0, cpu_addr} >= SCR_LO) && ({1'b0, cpu_addr} < SCR_HI);
  assign cpu_off = cpu_addr[VRAM_AW-1:0] - SCR_BASE[VRAM_AW-1:0];

  assign resv      = phase_reserved(RESV_MASK, vid_phase);
  assign free_slot = ~resv;

  // Strobes are only accepted while no read is outstanding.
  assign wr_hit = cpu_we & hit & (st_q == RD_IDLE);
  assign rd_hit = cpu_rd & hit & (st_q == RD_IDLE);
  assign push   = wr_hit & ~fifo_full;
  assign pop    = free_slot & ~fifo_empty;
  // A fresh read can use the strobe cycle itself when nothing is queued ahead of it.
  assign rd_go  = free_slot & fifo_empty &
                  ((st_q == RD_PEND) | (rd_hit & ~wr_hit));

  assign wr_ent = '{addr: cpu_off, data: cpu_wdata};

  zx_sync_fifo #(
    .WIDTH ($bits(vram_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .wdata_i (wr_ent),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (reset) begin
      ram_addr = '0;
    end else if (resv) begin
      ram_addr = video_addr;
    end else if (pop) begin
      ram_addr  = head.addr;
      ram_wdata = head.data;
      ram_we    = 1'b1;
    end else if (rd_go) begin
      ram_addr = (st_q == RD_PEND) ? rd_off_q : cpu_off;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= RD_IDLE;
      rd_off_q     <= '0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      video_data_q <= '0;
      resv_q       <= 1'b0;
    end else begin
      resv_q       <= resv;
      cpu_rvalid_q <= 1'b0;
      if (resv_q) video_data_q <= ram_rdata;
      case (st_q)
        RD_IDLE: begin
          if (rd_hit) begin
            rd_off_q <= cpu_off;
            st_q     <= rd_go ? RD_DATA : RD_PEND;
          end
        end
        RD_PEND: begin
          if (rd_go) st_q <= RD_DATA;
        end
        RD_DATA: begin
          cpu_rdata_q  <= ram_rdata;
          cpu_rvalid_q <= 1'b1;
          st_q         <= RD_IDLE;
        end
        default: st_q <= RD_IDLE;
      endcase
    end
  end

  assign video_data = video_data_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_wait   = fifo_full | (st_q != RD_IDLE);

endmodule
